// File: rtl/seq_divider.sv
// seq_divider
//   Multicycle signed 32-bit restoring divider for the MIPS datapath.
//   A start pulse in IDLE latches the operand signs and magnitudes.
//   CALC then runs one restoring step per cycle for 32 cycles.
//   FIX applies the signs and writes Hi/Lo, and DONE pulses done for one cycle.
//   A zero divisor skips the arithmetic entirely. It raises div_zero and
//   leaves hi/lo holding their previous values.
//
//   Optional feature macro: DIV_EARLY_EXIT_EN
//     When this macro is defined and |dividend| < |divisor|, CALC is skipped.
//     The quotient is 0 and the remainder is |dividend|.
//     When it is undefined, every non-zero-divisor operation takes the fixed
//     34-cycle path.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   operation request, sampled only in IDLE
//   dividend  in   [31:0] signed dividend (register A)
//   divisor   in   [31:0] signed divisor (register B)
//   hi        out  [31:0] signed remainder (sign of dividend)
//   lo        out  [31:0] signed quotient
//   busy      out  high in any state other than IDLE
//   done      out  one-cycle pulse while in DONE
//   div_zero  out  divisor was zero on the last accepted start

module seq_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sign_dvd_q, sign_dvd_d;
    logic        sign_dvs_q, sign_dvs_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] mag_q, mag_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dz_q, dz_d;

    logic [31:0] abs_dvd;
    logic [31:0] abs_dvs;
    logic [32:0] rem_shift;
    logic [32:0] trial;

    always_comb begin
        // 0x80000000 negates to itself, which is the correct unsigned magnitude.
        abs_dvd = dividend[31] ? (32'd0 - dividend) : dividend;
        abs_dvs = divisor[31]  ? (32'd0 - divisor)  : divisor;

        // The stored remainder is always below |divisor| <= 2^31.
        // Its shifted value therefore fits in 33 bits.
        // Bit 32 of the trial difference is the borrow.
        rem_shift = {rem_q, quo_q[31]};
        trial     = rem_shift - {1'b0, mag_q};

        state_d    = state_q;
        sign_dvd_d = sign_dvd_q;
        sign_dvs_d = sign_dvs_q;
        quo_d      = quo_q;
        mag_d      = mag_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dz_d       = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_dvd_d = dividend[31];
                    sign_dvs_d = divisor[31];
                    quo_d      = abs_dvd;
                    mag_d      = abs_dvs;
                    rem_d      = '0;
                    cnt_d      = 5'd31;
                    dz_d       = 1'b0;
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
`ifdef DIV_EARLY_EXIT_EN
                        if (abs_dvd < abs_dvs) begin
                            quo_d   = '0;
                            rem_d   = abs_dvd;
                            state_d = S_FIX;
                        end else begin
                            state_d = S_CALC;
                        end
`else
                        state_d = S_CALC;
`endif
                    end
                end
            end

            S_CALC: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end

            S_FIX: begin
                lo_d    = (sign_dvd_q ^ sign_dvs_q) ? (32'd0 - quo_q) : quo_q;
                hi_d    = sign_dvd_q ? (32'd0 - rem_q) : rem_q;
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sign_dvd_q <= 1'b0;
            sign_dvs_q <= 1'b0;
            quo_q      <= '0;
            mag_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_dvd_q <= sign_dvd_d;
            sign_dvs_q <= sign_dvs_d;
            quo_q      <= quo_d;
            mag_q      <= mag_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dz_q       <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider.
// Expected results are queued when an operation is started.
// They are popped when done is observed.

module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    typedef struct {
        string       tag;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    seq_divider dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    // Independent reference: native unsigned divide on magnitudes, then sign fix-up.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        q = mag(a) / mag(b);
        r = mag(a) % mag(b);
        return {(a[31] ? (32'd0 - r) : r), ((a[31] ^ b[31]) ? (32'd0 - q) : q)};
    endfunction

    // Starts one operation, queues its expectation and waits (bounded) for done.
    // The operands are scrambled after the start edge, so they must have been latched.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int repulse);
        exp_t e;
        exp_t g;
        bit   got;
        e.tag = tag;
        if (b == '0) begin
            e.lo  = last_lo;
            e.hi  = last_hi;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            e.lo  = exp_lo;
            e.hi  = exp_hi;
            e.dz  = 1'b0;
            e.lat = 34;
`ifdef DIV_EARLY_EXIT_EN
            if (mag(a) < mag(b)) e.lat = 2;
`endif
        end
        sb.push_back(e);

        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        got = 1'b0;
        for (int cyc = 1; cyc <= 60 && !got; cyc++) begin
            @(negedge clk);
            start    = (repulse != 0 && cyc == repulse);
            dividend = $urandom;
            divisor  = $urandom;
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            if (done) begin
                got = 1'b1;
                g = sb.pop_front();
                chk({g.tag, " latency"}, 32'(cyc), 32'(g.lat));
                chk({g.tag, " lo"}, lo, g.lo);
                chk({g.tag, " hi"}, hi, g.hi);
                chk({g.tag, " div_zero"}, {31'd0, div_zero}, {31'd0, g.dz});
                last_lo = g.lo;
                last_hi = g.hi;
            end
        end
        start = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s timeout: observed=no done expected=done within 60 cycles", tag);
            void'(sb.pop_front());
        end
        @(negedge clk);
        chk({tag, " done after"}, {31'd0, done}, 32'd0);
        chk({tag, " busy after"}, {31'd0, busy}, 32'd0);
        chk({tag, " lo hold"}, lo, last_lo);
    endtask

    initial begin
        logic [63:0] m;
        logic [31:0] ra, rb;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset div_zero", {31'd0, div_zero}, 32'd0);
        reset = 1'b0;

        run_op("7/2",   32'd7,        32'd2,        32'h0000_0003, 32'h0000_0001, 0);
        run_op("-7/2",  32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_op("7/-2",  32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 0);
        run_op("451/20", 32'h451,     32'h20,       32'h0000_0022, 32'h0000_0011, 0);
        run_op("7/0",   32'd7,        32'd0,        32'h0, 32'h0, 0);
        chk("7/0 hi kept", hi, 32'h11);
        chk("7/0 lo kept", lo, 32'h22);
        run_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 10);

        // Abort 100/3 with reset at cycle 15.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("abort busy before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        chk("abort div_zero", {31'd0, div_zero}, 32'd0);
        last_hi = '0;
        last_lo = '0;
        repeat (40) begin
            @(negedge clk);
            n_cmp++;
            assert (done === 1'b0) else begin
                n_bad++;
                $error("FAIL abort stray done: observed=%b expected=0", done);
            end
        end

        run_op("100/3", 32'd100, 32'd3, 32'd33, 32'd1, 0);
        run_op("5/9",   32'd5,   32'd9, 32'd0,  32'd5, 0);
        run_op("0/-5",  32'd0,   32'hFFFF_FFFB, 32'd0, 32'd0, 0);
        run_op("-8/min", 32'hFFFF_FFF8, 32'h8000_0000, 32'd0, 32'hFFFF_FFF8, 0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> (i * 5);
            if (rb == '0) rb = 32'd13;
            if (i[0]) rb = 32'd0 - rb;
            m = model(ra, rb);
            run_op($sformatf("rand%0d", i), ra, rb, m[31:0], m[63:32], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
